// File: rtl/data_mem_ctrl.sv
// Data-memory slave for the load/store unit: word-organised RAM with byte-lane
// writes, configurable grant wait states and response latency, one outstanding transfer.
module data_mem_ctrl #(
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH_WORDS  = 1024,
  parameter int GNT_WAIT     = 0,
  parameter int RESP_LATENCY = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  data_req_i,
  output logic                  data_gnt_o,
  output logic                  data_rvalid_o,
  input  logic [31:0]           data_addr_i,
  input  logic                  data_we_i,
  input  logic [3:0]            data_be_i,
  input  logic [DATA_WIDTH-1:0] data_wdata_i,
  output logic [DATA_WIDTH-1:0] data_rdata_o,
  output logic                  data_err_o
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LAT = 4'(RESP_LATENCY);
  localparam logic [3:0] GW  = 4'(GNT_WAIT);

  typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_t;

  state_t                state;
  state_t                next_state;
  logic [3:0]            resp_cnt;
  logic [3:0]            next_resp_cnt;
  logic [3:0]            wait_cnt;
  logic                  ready;
  logic                  gnt;
  logic                  rvalid;
  logic                  in_range;
  logic [AW-1:0]         word_idx;
  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] rdata_hold;
  logic                  err_q;
  logic                  unused_addr_lsbs;

  assign word_idx         = data_addr_i[2 +: AW];
  assign in_range         = (data_addr_i[31:2+AW] == '0);
  assign unused_addr_lsbs = ^data_addr_i[1:0];

  always_comb begin
    ready  = (state == IDLE) || ((state == RESP) && (resp_cnt == LAT));
    gnt    = data_req_i && ready && (wait_cnt == GW);
    rvalid = (state == RESP) && (resp_cnt == LAT);
  end

  // A grant in the final response cycle keeps the FSM in RESP and restarts the count.
  always_comb begin
    next_state    = state;
    next_resp_cnt = resp_cnt;
    case (state)
      IDLE: begin
        if (gnt) begin
          next_state    = RESP;
          next_resp_cnt = 4'd1;
        end else begin
          next_state    = IDLE;
          next_resp_cnt = 4'd0;
        end
      end
      RESP: begin
        if (gnt) begin
          next_state    = RESP;
          next_resp_cnt = 4'd1;
        end else if (resp_cnt == LAT) begin
          next_state    = IDLE;
          next_resp_cnt = 4'd0;
        end else begin
          next_state    = RESP;
          next_resp_cnt = resp_cnt + 4'd1;
        end
      end
      default: begin
        next_state    = IDLE;
        next_resp_cnt = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      resp_cnt <= 4'd0;
    end else begin
      state    <= next_state;
      resp_cnt <= next_resp_cnt;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wait_cnt <= 4'd0;
    end else if (!data_req_i || gnt) begin
      wait_cnt <= 4'd0;
    end else if (ready) begin
      wait_cnt <= wait_cnt + 4'd1;
    end else begin
      wait_cnt <= wait_cnt;
    end
  end

  // Response is captured at the grant edge; rdata_hold keeps the last delivered word.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_q    <= '0;
      err_q      <= 1'b0;
      rdata_hold <= '0;
    end else begin
      if (gnt) begin
        if (!in_range) begin
          rdata_q <= '0;
          err_q   <= 1'b1;
        end else if (data_we_i) begin
          rdata_q <= '0;
          err_q   <= 1'b0;
        end else begin
          rdata_q <= mem[word_idx];
          err_q   <= 1'b0;
        end
      end
      if (rvalid) begin
        rdata_hold <= rdata_q;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (gnt && data_we_i && in_range) begin
      for (int i = 0; i < 4; i++) begin
        if (data_be_i[i]) begin
          mem[word_idx][8*i +: 8] <= data_wdata_i[8*i +: 8];
        end
      end
    end
  end

  assign data_gnt_o    = gnt;
  assign data_rvalid_o = rvalid;
  assign data_rdata_o  = rvalid ? rdata_q : rdata_hold;
  assign data_err_o    = rvalid & err_q;

endmodule
